// File: rtl/sync_fifo_parity.sv
// Single-clock FIFO that stores an even-parity bit with each word.
// The parity is checked on readout and reported as pe alongside dout.
module sync_fifo_parity #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     inj_err,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     pe,
  output logic                     full,
  output logic                     empty,
  output logic                     afull,
  output logic                     aempty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  // Each entry is {parity, data}.
  logic [WIDTH:0]     mem_q [DEPTH];

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               dv_q, dv_d;
  logic               pe_q, pe_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;

  logic               full_w;
  logic               empty_w;
  logic               rd_acc;
  logic               wr_acc;
  logic [WIDTH:0]     rd_word;
  logic               wr_par;

  // Status flags decode straight from the count register.
  always_comb begin
    full_w  = (count_q == DEPTH_C);
    empty_w = (count_q == '0);
  end

  // Accept logic: a read frees a slot, so a full FIFO can still take a write.
  always_comb begin
    rd_acc  = rd_en && !empty_w;
    wr_acc  = wr_en && (!full_w || rd_acc);
    rd_word = mem_q[rd_ptr_q];
    wr_par  = (^din) ^ inj_err;
  end

  // Next-state for pointers, occupancy, read port and sticky errors.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    dv_d     = 1'b0;
    pe_d     = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = rd_word[WIDTH-1:0];
      dv_d     = 1'b1;
      pe_d     = (^rd_word[WIDTH-1:0]) ^ rd_word[WIDTH];
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (wr_en && !wr_acc) begin
      ovf_d = 1'b1;
    end

    if (rd_en && empty_w) begin
      udf_d = 1'b1;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= {wr_par, din};
    end
  end

  // Control and read-port registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      pe_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      pe_q     <= pe_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Output mapping.
  always_comb begin
    dout       = dout_q;
    dout_valid = dv_q;
    pe         = pe_q;
    count      = count_q;
    full       = full_w;
    empty      = empty_w;
    afull      = (count_q >= AFULL_C);
    aempty     = (count_q <= AEMPTY_C);
    overflow   = ovf_q;
    underflow  = udf_q;
  end

endmodule

// File: doc/sync_fifo_parity.md
Name: sync_fifo_parity

Overview:
- Parametrised single-clock FIFO with per-word parity protection; successor to the fixed 8-bit din/dout/pe transfer path.
- Buffers WIDTH-bit words, stores an even-parity bit alongside each word, checks parity on readout, and reports pe aligned with dout.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow flags, and parity-error injection for verification.
- Sits between a bursty producer and a consumer in the same clock domain.

Parameters:
- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 16, number of entries; power of 2, ≥4.
- AFULL_TH, 12, afull asserted when count ≥ AFULL_TH.
- AEMPTY_TH, 4, aempty asserted when count ≤ AEMPTY_TH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- din  in  WIDTH  write data.
- inj_err  in  1  when high with an accepted write, the stored parity bit is inverted.
- rd_en  in  1  read request.
- dout  out  WIDTH  read data, registered.
- dout_valid  out  1  one-cycle pulse; dout/pe valid this cycle.
- pe  out  1  parity error on the current dout; qualified by dout_valid.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- afull  out  1  count ≥ AFULL_TH.
- aempty  out  1  count ≤ AEMPTY_TH.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: write attempted while full and not read.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (asynchronous, active-high): pointers=0, count=0, dout=0, dout_valid=0, pe=0, overflow=0, underflow=0. Flags follow: empty=1, aempty=1, full=0, afull=0. Memory contents are not cleared.
- Storage: DEPTH × (WIDTH+1) array. The stored bit is ^din XOR inj_err.
- Pointers: log2(DEPTH) bits; wrap from DEPTH-1 to 0 naturally.
- count: separate register, +1 on write-only, −1 on read-only, unchanged on both or neither.
- Write accepted: wr_en && (!full || rd_accepted).
- Read accepted: rd_en && !empty.
- Simultaneous read+write:
  - When full: both accepted, count stays DEPTH, no overflow.
  - When empty: write accepted, read rejected and underflow set. There is no fall-through.
- Read latency: 1 cycle. On a read accepted at edge N, dout, dout_valid=1 and pe are registered at edge N (visible in cycle N+1).
  - pe = (^data_stored) XOR parity_stored.
  - dout holds its last value when there is no read. dout_valid and pe return to 0 when there is no read.
- Rejected write when full (no read): data dropped, pointers unchanged, overflow set.
- Rejected read when empty: no pointer change, dout_valid=0, underflow set.
- overflow and underflow clear only on rst.
- Flags are derived combinationally from the count register, so they are glitch-free relative to clk and update in the same cycle as count.
- Reset asserted mid-burst: all state is discarded at once. The first write after deassertion lands at address 0.
- inj_err is ignored when the write is not accepted.

Test Plan:
- Reset, then write 0x00..0x0F (16 words, WIDTH=8, DEPTH=16) → full=1 after the 16th, count=16, afull=1 from count=12; a 17th write sets overflow=1 and count stays 16.
- Read all 16 → dout sequence 0x00..0x0F, each with dout_valid pulse one cycle after rd_en, pe=0; empty=1 at the end; a further read sets underflow=1 with no dout_valid.
- Write 0xA5 with inj_err=1, then 0x3C with inj_err=0; read both → pe=1 with dout=0xA5, pe=0 with dout=0x3C.
- Fill to 16, then hold wr_en=rd_en=1 for 20 cycles → count stays 16, overflow stays 0, data order preserved across pointer wrap.
- From empty, assert wr_en=rd_en=1 with din=0x77 → write accepted, count=1, underflow=1; next cycle read → dout=0x77.
- Write 5 words, assert rst mid-cycle (asynchronous) → count=0, empty=1, dout_valid=0 immediately; write 0x11 and read → dout=0x11.
